// File: rtl/mult_unit_pkg.sv
// Shared types and constants for the iterative 32x32 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_unit_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_FIX_LO = 3'd2,
        ST_FIX_HI = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Absolute value used at operand capture; the most negative value maps
    // onto itself, which is the correct magnitude when read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        return (sgn & v[WIDTH-1]) ? (~v + one) : v;
    endfunction

endpackage

// File: rtl/mult_unit_fulladder.sv
// 32-bit ripple-carry adder shared by every datapath step of the multiplier.
// Latency: purely combinational.
// Backpressure: none.
module fulladder #(
    parameter int W = 32
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         cin,
    output logic [W-1:0] y,
    output logic         cout
);

    // Bit-serial carry ripple from LSB to MSB.
    always_comb begin
        logic carry;
        y     = '0;
        carry = cin;
        for (int i = 0; i < W; i++) begin
            y[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/mult_unit.sv
// Sequential shift-add 32x32 multiplier, signed or unsigned, 64-bit result on hi/lo.
// Latency: fixed 34 cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is ignored while busy; a start in the DONE cycle is accepted.
module mult_unit
    import mult_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    state_t             next_state;
    logic               accept;

    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   p_hi;
    logic [WIDTH-1:0]   p_lo;
    logic [CNT_W-1:0]   count;
    logic               neg;
    logic               fc;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_y;
    logic               add_cout;

    // Single adder: accumulate partial products in RUN, then two's-complement
    // the magnitude product one half at a time in FIX_LO / FIX_HI.
    fulladder #(.W(WIDTH)) u_adder (
        .A    (add_a),
        .B    (add_b),
        .cin  (add_cin),
        .y    (add_y),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (count == CNT_W'(STEPS - 1)) begin
                    next_state = ST_FIX_LO;
                end
            end
            ST_FIX_LO: begin
                busy       = 1'b1;
                next_state = ST_FIX_HI;
            end
            ST_FIX_HI: begin
                busy       = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_RUN;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Adder operand steering by state; inactive states feed zeros.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            ST_RUN: begin
                add_a = p_hi;
                add_b = p_lo[0] ? m : '0;
            end
            ST_FIX_LO: begin
                add_a   = neg ? ~p_lo : p_lo;
                add_cin = neg;
            end
            ST_FIX_HI: begin
                add_a   = neg ? ~p_hi : p_hi;
                add_cin = neg & fc;
            end
            default: ;
        endcase
    end

    // Operand capture, shift-add iteration and result sign fix-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m     <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            count <= '0;
            neg   <= 1'b0;
            fc    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            neg   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            m     <= magnitude(A, is_signed);
            p_hi  <= '0;
            p_lo  <= magnitude(B, is_signed);
            count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    p_hi  <= {add_cout, add_y[WIDTH-1:1]};
                    p_lo  <= {add_y[0], p_lo[WIDTH-1:1]};
                    count <= count + CNT_W'(1);
                end
                ST_FIX_LO: begin
                    lo <= add_y;
                    fc <= add_cout;
                end
                ST_FIX_HI: begin
                    hi <= add_y;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: scoreboard of expected 64-bit products.
// Latency: each operation expects done exactly 34 cycles after start is sampled.
// Backpressure: exercises ignored starts while busy and acceptance in DONE.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb[$];

    mult_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .A         (a_in),
        .B         (b_in),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Reference product: sign- or zero-extend to 64 bits, low 64 bits of the product.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Present one start for one cycle; on return we sit at the falling edge after edge E.
    task automatic drive_start(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        a_in      = a;
        b_in      = b;
        sb.push_back(model(s, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges until done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a_in      = '0;
        b_in      = '0;
        #3;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_status: busy/done=%b expected 00", {busy, done});
        end
        checks++;
        if ({hi, lo} !== 64'h0) begin
            failures++;
            $display("FAIL reset_result: hi/lo=%h expected 0", {hi, lo});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_unsigned_max();
        int          cyc;
        logic [63:0] expv;
        drive_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL umax_busy: busy=%b expected 1", busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 34) begin
            failures++;
            $display("FAIL umax_latency: done after %0d cycles expected 34", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL umax_result: scoreboard empty");
        end else begin
            expv = sb.pop_front();
            if ({hi, lo} !== expv) begin
                failures++;
                $display("FAIL umax_result: hi/lo=%h expected %h", {hi, lo}, expv);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || {hi, lo} !== expv) begin
                failures++;
                $display("FAIL umax_hold: done=%b hi/lo=%h expected done=0 hi/lo=%h", done, {hi, lo}, expv);
            end
        end
    endtask

    task automatic test_signed_cases();
        logic        s_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] a_tab[5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0000};
        logic [31:0] b_tab[5] = '{32'h0000_0007, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0002};
        int          cyc;
        logic [63:0] expv;
        for (int i = 0; i < 5; i++) begin
            drive_start(s_tab[i], a_tab[i], b_tab[i]);
            wait_done(cyc);
            checks++;
            if (cyc != 34) begin
                failures++;
                $display("FAIL case%0d_latency: done after %0d cycles expected 34", i, cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL case%0d_result: scoreboard empty", i);
            end else begin
                expv = sb.pop_front();
                if ({hi, lo} !== expv) begin
                    failures++;
                    $display("FAIL case%0d_result: hi/lo=%h expected %h", i, {hi, lo}, expv);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int          dones = 0;
        int          first = -1;
        logic [63:0] got   = '0;
        logic [63:0] expv;
        drive_start(1'b0, 32'd5, 32'd6);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a_in  = 32'd9;
        b_in  = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int n = 6; n <= 45; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (first < 0) begin
                    first = n;
                    got   = {hi, lo};
                end
            end
        end
        checks++;
        if (dones != 1 || first != 34) begin
            failures++;
            $display("FAIL ignore_done: %0d pulses first at %0d expected 1 pulse at 34", dones, first);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL ignore_result: scoreboard empty");
        end else begin
            expv = sb.pop_front();
            if (got !== expv) begin
                failures++;
                $display("FAIL ignore_result: hi/lo=%h expected %h", got, expv);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int          cyc;
        logic [63:0] expv;
        drive_start(1'b0, 32'd5, 32'd7);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || {hi, lo} !== 64'h0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b done=%b hi/lo=%h expected 0 0 0", busy, done, {hi, lo});
        end
        sb.delete();
        @(negedge clk);
        reset     = 1'b0;
        start     = 1'b1;
        is_signed = 1'b0;
        a_in      = 32'd2;
        b_in      = 32'd3;
        sb.push_back(model(1'b0, 32'd2, 32'd3));
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc != 34) begin
            failures++;
            $display("FAIL post_reset_latency: done after %0d cycles expected 34", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL post_reset_result: scoreboard empty");
        end else begin
            expv = sb.pop_front();
            if ({hi, lo} !== expv) begin
                failures++;
                $display("FAIL post_reset_result: hi/lo=%h expected %h", {hi, lo}, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        int          cyc2;
        logic [63:0] expv;
        drive_start(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(cyc);
        checks++;
        if (cyc != 34 || sb.size() == 0) begin
            failures++;
            $display("FAIL b2b_first: done after %0d cycles queue=%0d expected 34 and 1", cyc, sb.size());
        end else begin
            expv = sb.pop_front();
            checks++;
            if ({hi, lo} !== expv) begin
                failures++;
                $display("FAIL b2b_first_result: hi/lo=%h expected %h", {hi, lo}, expv);
            end
        end
        start     = 1'b1;
        is_signed = 1'b0;
        a_in      = 32'h1234_5678;
        b_in      = 32'h9ABC_DEF0;
        sb.push_back(model(1'b0, 32'h1234_5678, 32'h9ABC_DEF0));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: done=%b busy=%b expected 0 1", done, busy);
        end
        wait_done(cyc2);
        checks++;
        if (cyc2 + 1 != 35) begin
            failures++;
            $display("FAIL b2b_spacing: second done %0d cycles after first expected 35", cyc2 + 1);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL b2b_second_result: scoreboard empty");
        end else begin
            expv = sb.pop_front();
            if ({hi, lo} !== expv) begin
                failures++;
                $display("FAIL b2b_second_result: hi/lo=%h expected %h", {hi, lo}, expv);
            end
        end
    endtask

    task automatic test_random();
        int          cyc;
        logic [63:0] expv;
        for (int i = 0; i < 6; i++) begin
            drive_start(1'($urandom_range(0, 1)), $urandom, $urandom);
            wait_done(cyc);
            checks++;
            if (cyc != 34 || sb.size() == 0) begin
                failures++;
                $display("FAIL rand%0d_done: done after %0d cycles queue=%0d expected 34 and 1", i, cyc, sb.size());
            end else begin
                expv = sb.pop_front();
                if ({hi, lo} !== expv) begin
                    failures++;
                    $display("FAIL rand%0d_result: hi/lo=%h expected %h", i, {hi, lo}, expv);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_cases();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
